// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^N) arithmetic blocks: the engine state
// encoding, the default GF(2^6) reduction polynomial and the sizing helper
// for the exponent bit counter.
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf_state_e;

    // Low bits of x^6 + x + 1; the x^6 term is implicit.
    localparam logic [5:0] GF6_POLY = 6'b000011;

    // Width needed to count N-1 down to 0, never less than one bit.
    function automatic int unsigned gf_cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gf_mult_pb.sv
// Combinational polynomial-basis multiplier over GF(2^N).
// The product is accumulated MSB-first (Horner form): each step multiplies
// the running sum by alpha, reduces it immediately, then adds a if the
// current bit of b is set, so intermediate values never exceed N bits.
module gf_mult_pb
    import gf_pkg::*;
#(
    parameter int unsigned   N    = 6,
    parameter logic [N-1:0]  POLY = GF6_POLY
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] p_o
);

    logic [N-1:0] r;

    // Shift-reduce-add chain over the bits of b, most significant first.
    always_comb begin
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            r = {r[N-2:0], 1'b0} ^ (r[N-1] ? POLY : '0) ^ (b_i[N-1-i] ? a_i : '0);
        end
        p_o = r;
    end

endmodule

// File: rtl/gf_pow_seq.sv
// Sequential GF(2^N) exponentiation engine: y = x^e by MSB-first
// square-and-multiply, one exponent bit per clock, with valid/ready
// handshakes on the operand and result sides.
module gf_pow_seq
    import gf_pkg::*;
#(
    parameter int unsigned   N    = 6,
    parameter logic [N-1:0]  POLY = GF6_POLY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_x,
    input  logic [N-1:0] in_e,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_y
);

    localparam int unsigned     CW      = gf_cnt_width(N);
    localparam logic [CW-1:0]   CNT_TOP = CW'(N - 1);

    gf_state_e     state_q, state_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  e_q, e_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  sq;
    logic [N-1:0]  prod;
    logic [N-1:0]  step;

    gf_mult_pb #(
        .N    (N),
        .POLY (POLY)
    ) u_square (
        .a_i (acc_q),
        .b_i (acc_q),
        .p_o (sq)
    );

    gf_mult_pb #(
        .N    (N),
        .POLY (POLY)
    ) u_multiply (
        .a_i (sq),
        .b_i (x_q),
        .p_o (prod)
    );

    assign step      = e_q[cnt_q] ? prod : sq;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_y     = acc_q;

    // Next-state logic: accept in IDLE, step one exponent bit per cycle in
    // RUN, hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        e_d     = e_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    e_d     = in_e;
                    acc_d   = N'(1);
                    cnt_d   = CNT_TOP;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = step;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            e_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            e_q     <= e_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gf_pow_seq.sv
// Self-checking bench for gf_pow_seq: one N=6 instance with the default
// polynomial and one N=8 instance with x^8+x^4+x^3+x+1, sharing stimulus
// through a select line. Expected results come from a reference model
// (repeated multiplication) or hand-derived constants and are queued at
// acceptance, then popped at the result handshake.
module tb_gf_pow_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_x;
    logic [7:0] in_e;
    logic       out_ready;
    logic       sel8;

    logic       ir6, ov6, ir8, ov8;
    logic [5:0] y6;
    logic [7:0] y8;

    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_y;

    int         cyc = 0;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] exp_q[$];

    gf_pow_seq #(
        .N    (6),
        .POLY (6'b000011)
    ) dut6 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~sel8),
        .in_ready  (ir6),
        .in_x      (in_x[5:0]),
        .in_e      (in_e[5:0]),
        .out_valid (ov6),
        .out_ready (out_ready & ~sel8),
        .out_y     (y6)
    );

    gf_pow_seq #(
        .N    (8),
        .POLY (8'h1B)
    ) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & sel8),
        .in_ready  (ir8),
        .in_x      (in_x),
        .in_e      (in_e),
        .out_valid (ov8),
        .out_ready (out_ready & sel8),
        .out_y     (y8)
    );

    assign in_ready  = sel8 ? ir8 : ir6;
    assign out_valid = sel8 ? ov8 : ov6;
    assign out_y     = sel8 ? y8 : {2'b00, y6};

    always #5 clk = ~clk;

    // Count rising edges so acceptance times can be compared.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Full carry-less product followed by long-division reduction.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b,
                                         input int n, input logic [7:0] poly);
        logic [31:0] p;
        logic [31:0] m;
        p = '0;
        for (int i = 0; i < n; i++)
            if (b[i]) p = p ^ ({24'd0, a} << i);
        m = {24'd0, poly} | (32'd1 << n);
        for (int k = 2 * n - 2; k >= n; k--)
            if (p[k]) p = p ^ (m << (k - n));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_pow(input logic [7:0] x, input logic [7:0] e,
                                         input int n, input logic [7:0] poly);
        logic [7:0] y;
        y = 8'd1;
        for (int i = 0; i < int'(e); i++) y = m_mul(y, x, n, poly);
        return y;
    endfunction

    // Entered and left just after a falling edge. Returns the cycle of the
    // accepting edge and the latency in edges until out_valid was seen.
    task automatic do_op(input logic [7:0] x, input logic [7:0] e, input logic [7:0] expv,
                         input int stall_pct, output int lat, output int acc_cyc);
        int g;
        logic [7:0] want;
        in_x = x; in_e = e; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin @(negedge clk); g++; end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0; lat = -1; acc_cyc = -1;
            return;
        end
        exp_q.push_back(expv);
        acc_cyc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0; in_x = 8'($urandom); in_e = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        if (!out_valid) begin
            total_cnt++;
            want = exp_q.pop_front();
            $display("FAIL result_timeout: out_valid=%b required 1 (x=%h e=%h)", out_valid, x, e);
            return;
        end
        g = 0;
        forever begin
            out_ready = (g >= 20) || (int'($urandom_range(99)) >= stall_pct);
            if (out_ready) break;
            @(negedge clk);
            g++;
        end
        want = exp_q.pop_front();
        total_cnt++;
        if (out_y !== want)
            $display("FAIL result x=%h e=%h: out_y=%h required %h", x, e, out_y, want);
        else
            pass_cnt++;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel8 = 1'b0;
        in_x = '0; in_e = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({ir6, ov6, y6} !== {1'b1, 1'b0, 6'h00})
            $display("FAIL reset6: ir/ov/y=%b/%b/%h required 1/0/00", ir6, ov6, y6);
        else pass_cnt++;
        total_cnt++;
        if ({ir8, ov8, y8} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL reset8: ir/ov/y=%b/%b/%h required 1/0/00", ir8, ov8, y8);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] tx[7] = '{8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 8'h01, 8'h2A};
        logic [7:0] te[7] = '{8'd19, 8'd62, 8'd63, 8'd0, 8'd5, 8'h3F, 8'd1};
        logic [7:0] ty[7] = '{8'h1E, 8'h21, 8'h01, 8'h01, 8'h00, 8'h01, 8'h2A};
        int lat, ac;
        sel8 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_op(tx[i], te[i], ty[i], 0, lat, ac);
            total_cnt++;
            if (lat !== 6)
                $display("FAIL latency x=%h e=%h: %0d edges required 6", tx[i], te[i], lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, a1, a2;
        sel8 = 1'b0;
        do_op(8'h02, 8'd19, 8'h1E, 0, lat, a1);
        do_op(8'h02, 8'd63, 8'h01, 0, lat, a2);
        total_cnt++;
        if (a2 - a1 !== 8)
            $display("FAIL throughput: acceptance spacing %0d required 8", a2 - a1);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int g, hc;
        sel8 = 1'b0;
        in_x = 8'h02; in_e = 8'd19; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 40) begin @(negedge clk); g++; end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_x = 8'($urandom); in_e = 8'($urandom);
            total_cnt++;
            if ({out_valid, out_y, in_ready} !== {1'b1, 8'h1E, 1'b0})
                $display("FAIL stall cycle %0d: ov/y/ir=%b/%h/%b required 1/1e/0",
                         i, out_valid, out_y, in_ready);
            else pass_cnt++;
            @(negedge clk);
        end
        in_x = 8'h2A; in_e = 8'd1; out_ready = 1'b1;
        hc = cyc + 1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 40) begin @(negedge clk); g++; end
        total_cnt++;
        if (cyc !== hc + 1 + 6)
            $display("FAIL release_spacing: result after edge %0d required %0d", cyc, hc + 7);
        else pass_cnt++;
        total_cnt++;
        if (out_y !== 8'h2A)
            $display("FAIL post_release: out_y=%h required 2a", out_y);
        else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        int g, lat, ac;
        sel8 = 1'b0;
        in_x = 8'h02; in_e = 8'd19; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({out_valid, out_y, in_ready} !== {1'b0, 8'h00, 1'b1})
            $display("FAIL rst_run: ov/y/ir=%b/%h/%b required 0/00/1", out_valid, out_y, in_ready);
        else pass_cnt++;
        in_x = 8'h03; in_e = 8'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 40) begin @(negedge clk); g++; end
        out_ready = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, out_y, in_ready} !== {1'b0, 8'h00, 1'b1})
            $display("FAIL rst_done: ov/y/ir=%b/%h/%b required 0/00/1", out_valid, out_y, in_ready);
        else pass_cnt++;
        do_op(8'h02, 8'd19, 8'h1E, 0, lat, ac);
    endtask

    task automatic test_sweep6();
        int lat, ac;
        sel8 = 1'b0;
        for (int x = 0; x < 64; x++)
            for (int e = 0; e < 64; e++)
                do_op(8'(x), 8'(e), m_pow(8'(x), 8'(e), 6, 8'h03), 25, lat, ac);
    endtask

    task automatic test_sweep8();
        int lat, ac;
        logic [7:0] x, e;
        sel8 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom);
            e = 8'($urandom);
            do_op(x, e, m_pow(x, e, 8, 8'h1B), 25, lat, ac);
        end
        sel8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        test_sweep6();
        test_sweep8();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
